// File: rtl/maxpool_drain_control_pkg.sv
// Shared pooling-stage definitions: map geometry helpers and the pass FSM
// state encoding used by both the fill control and the drain control.
package maxpool_pkg;

  typedef enum logic [1:0] {
    POOL_IDLE  = 2'd0,
    POOL_DRAIN = 2'd1,
    POOL_DONE  = 2'd2
  } pool_state_e;

  function automatic int out_size_f(input int matrix_size);
    return matrix_size / 2;
  endfunction

  function automatic int map_words_f(input int matrix_size);
    int side;
    side = out_size_f(matrix_size);
    return side * side;
  endfunction

endpackage

// File: rtl/maxpool_drain_control_if.sv
// Lane result handshake plus output-memory write port of the drain control.
interface maxpool_drain_control_if #(
  parameter int array_size = 9,
  parameter int data_width = 16,
  parameter int add_size   = 15
) ();

  logic [array_size-1:0]            pool_valid;
  logic [array_size*data_width-1:0] pool_data;
  logic [array_size-1:0]            pool_ready;
  logic                             wr_en;
  logic [add_size-1:0]              wr_addr;
  logic [data_width-1:0]            wr_data;
  logic                             wr_ready;

  modport master (
    input  pool_valid, pool_data, wr_ready,
    output pool_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    output pool_valid, pool_data, wr_ready,
    input  pool_ready, wr_en, wr_addr, wr_data
  );

endinterface

// File: rtl/maxpool_drain_control_rr_arbiter.sv
// Round-robin lane arbiter: one-hot grant scanning from last_grant+1; the
// pointer only moves when the grant is actually consumed.
module rr_arbiter #(
  parameter int n_req = 9,
  parameter int idx_w = $clog2(n_req)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             restart,
  input  logic             advance,
  input  logic [n_req-1:0] req,
  output logic [n_req-1:0] gnt,
  output logic [idx_w-1:0] gnt_idx,
  output logic             gnt_valid
);

  logic [idx_w-1:0] last_grant_q, last_grant_d;

  always_comb begin
    int idx;
    idx       = 0;
    gnt       = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    for (int k = 1; k <= n_req; k++) begin
      idx = (int'(last_grant_q) + k) % n_req;
      if (!gnt_valid && req[idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = idx_w'(idx);
        gnt[idx]  = 1'b1;
      end
    end

    last_grant_d = last_grant_q;
    if (restart)
      last_grant_d = idx_w'(n_req - 1);
    else if (advance && gnt_valid)
      last_grant_d = gnt_idx;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      last_grant_q <= idx_w'(n_req - 1);
    else
      last_grant_q <= last_grant_d;
  end

endmodule

// File: rtl/maxpool_drain_control.sv
// Drains one pooled result per window from each maxpool lane into a 1-deep
// hold register and writes them round-robin to the output feature-map buffer.
//
// state | meaning
// IDLE  | after reset, waiting for start
// DRAIN | accepting lane results and issuing writes
// DONE  | every lane written and last write accepted; waits for start
module maxpool_drain_control
  import maxpool_pkg::*;
#(
  parameter int matrix_size = 24,
  parameter int add_size    = 15,
  parameter int array_size  = 9,
  parameter int data_width  = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [add_size-1:0]       start_addr,
  maxpool_drain_control_if.master   bus,
  output logic [array_size-1:0]     lane_done,
  output logic                      busy,
  output logic                      done
);

  localparam int MAP_WORDS = map_words_f(matrix_size);
  localparam int CNT_W     = $clog2(MAP_WORDS + 1);
  localparam int IDX_W     = $clog2(array_size);

  localparam logic [1:0] ST_IDLE  = POOL_IDLE;
  localparam logic [1:0] ST_DRAIN = POOL_DRAIN;
  localparam logic [1:0] ST_DONE  = POOL_DONE;

  logic [1:0]                                state_q, state_d;
  logic [add_size-1:0]                       base_q, base_d;
  logic [array_size-1:0]                     hold_valid_q, hold_valid_d;
  logic [array_size-1:0][data_width-1:0]     hold_data_q, hold_data_d;
  logic [array_size-1:0][CNT_W-1:0]          count_q, count_d;
  logic [array_size-1:0]                     lane_done_q, lane_done_d;
  logic                                      wr_en_q, wr_en_d;
  logic [add_size-1:0]                       wr_addr_q, wr_addr_d;
  logic [data_width-1:0]                     wr_data_q, wr_data_d;

  logic                  in_drain;
  logic                  slot_free;
  logic                  start_acc;
  logic                  issue;
  logic [array_size-1:0] pool_ready;
  logic [array_size-1:0] gnt;
  logic [IDX_W-1:0]      gnt_idx;
  logic                  gnt_valid;

  assign in_drain   = (state_q == ST_DRAIN);
  assign slot_free  = !wr_en_q || bus.wr_ready;
  assign start_acc  = start && !in_drain;
  assign issue      = in_drain && slot_free && gnt_valid;
  assign pool_ready = in_drain ? (~hold_valid_q & ~lane_done_q) : '0;

  rr_arbiter #(
    .n_req (array_size),
    .idx_w (IDX_W)
  ) u_arb (
    .clk       (clk),
    .reset     (reset),
    .restart   (start_acc),
    .advance   (issue),
    .req       (hold_valid_q),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;
    count_d      = count_q;
    lane_done_d  = lane_done_q;
    wr_en_d      = wr_en_q;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d      = ST_DRAIN;
          base_d       = start_addr;
          hold_valid_d = '0;
          hold_data_d  = '0;
          count_d      = '0;
          lane_done_d  = '0;
          wr_en_d      = 1'b0;
        end
      end
      ST_DRAIN: begin
        for (int i = 0; i < array_size; i++) begin
          if (bus.pool_valid[i] && pool_ready[i]) begin
            hold_valid_d[i] = 1'b1;
            hold_data_d[i]  = bus.pool_data[i*data_width +: data_width];
          end
        end
        // A granted lane is never ready in the same cycle, so capture and
        // grant cannot collide on one hold register.
        if (issue) begin
          hold_valid_d     = hold_valid_d & ~gnt;
          count_d[gnt_idx] = count_q[gnt_idx] + CNT_W'(1);
          if (count_q[gnt_idx] == CNT_W'(MAP_WORDS - 1))
            lane_done_d[gnt_idx] = 1'b1;
          wr_en_d   = 1'b1;
          wr_addr_d = base_q + add_size'(int'(gnt_idx) * MAP_WORDS)
                             + add_size'(count_q[gnt_idx]);
          wr_data_d = hold_data_q[gnt_idx];
        end else if (bus.wr_ready) begin
          wr_en_d = 1'b0;
        end
        if ((&lane_done_q) && !wr_en_q)
          state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      base_q       <= '0;
      hold_valid_q <= '0;
      hold_data_q  <= '0;
      count_q      <= '0;
      lane_done_q  <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
      count_q      <= count_d;
      lane_done_q  <= lane_done_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
    end
  end

  assign bus.pool_ready = pool_ready;
  assign bus.wr_en      = wr_en_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign lane_done      = lane_done_q;
  assign busy           = in_drain;
  assign done           = (state_q == ST_DONE);

endmodule

// File: tb/tb_maxpool_drain_control.sv
// Scenario-table bench for the drain control: lane k's n-th result is
// k*256+n and must land at start_addr + k*144 + n in round-robin order.
module tb_maxpool_drain_control;

  localparam int AS = 9;
  localparam int DW = 16;
  localparam int AW = 15;
  localparam int MW = 144;

  typedef struct {
    logic [AW-1:0] base;
    logic [AS-1:0] lanes;
    bit            toggle;
    bit            rr;
    int            n_writes;
    int            restart_at;
    int            reset_at;
    logic [AS-1:0] exp_ld;
    bit            exp_done;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] start_addr;
  logic [AS-1:0] lane_done;
  logic          busy;
  logic          done;

  int n_err    = 0;
  int n_checks = 0;

  maxpool_drain_control_if #(.array_size(AS), .data_width(DW), .add_size(AW)) bus ();

  maxpool_drain_control #(
    .matrix_size (24),
    .add_size    (AW),
    .array_size  (AS),
    .data_width  (DW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .start_addr (start_addr),
    .bus        (bus),
    .lane_done  (lane_done),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int vi);
    int            sent [AS];
    int            writes;
    int            single;
    int            lane_e;
    int            n_e;
    int            e0;
    bit            stall;
    bit            restarted;
    bit            aborted;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_data;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;

    writes = 0; single = 0; stall = 0; restarted = 0; aborted = 0;
    s_addr = '0; s_data = '0;
    e0 = n_err;
    for (int k = 0; k < AS; k++) begin
      sent[k] = 0;
      if (v.lanes[k]) single = k;
    end

    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    bus.pool_valid = '0; bus.pool_data = '0; bus.wr_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_wr_en", 32'(bus.wr_en), 0);
    chk("rst_wr_addr", 32'(bus.wr_addr), 0);
    chk("rst_wr_data", 32'(bus.wr_data), 0);
    chk("rst_pool_ready", 32'(bus.pool_ready), 0);
    chk("rst_lane_done", 32'(lane_done), 0);
    reset = 1'b1;
    @(negedge clk);

    start = 1'b1; start_addr = v.base;
    @(negedge clk);
    start = 1'b0; start_addr = ~v.base;
    chk("start_busy", 32'(busy), 1);
    chk("start_pool_ready", 32'(bus.pool_ready), 32'h1FF);
    chk("start_wr_en", 32'(bus.wr_en), 0);

    for (int cyc = 0; cyc < 6000 && writes < v.n_writes; cyc++) begin
      if (stall) begin
        chk("stall_wr_en", 32'(bus.wr_en), 1);
        chk("stall_wr_addr", 32'(bus.wr_addr), 32'(s_addr));
        chk("stall_wr_data", 32'(bus.wr_data), 32'(s_data));
      end
      if (writes == v.reset_at) begin
        reset = 1'b0;
        #1;
        chk("abort_wr_en", 32'(bus.wr_en), 0);
        chk("abort_wr_addr", 32'(bus.wr_addr), 0);
        chk("abort_wr_data", 32'(bus.wr_data), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_pool_ready", 32'(bus.pool_ready), 0);
        chk("abort_lane_done", 32'(lane_done), 0);
        chk("abort_done", 32'(done), 0);
        aborted = 1;
        break;
      end
      for (int k = 0; k < AS; k++) begin
        bus.pool_valid[k] = v.lanes[k] && (sent[k] < MW);
        bus.pool_data[k*DW +: DW] = DW'(k*256 + sent[k]);
      end
      bus.wr_ready = v.toggle ? ((cyc % 2) == 1) : 1'b1;
      start = 1'b0;
      if (v.restart_at >= 0 && writes >= v.restart_at && !restarted) begin
        start = 1'b1; start_addr = 15'h5555; restarted = 1;
      end
      #1;
      if (bus.wr_en && bus.wr_ready) begin
        if (v.rr) begin
          lane_e = writes % AS; n_e = writes / AS;
        end else begin
          lane_e = single; n_e = writes;
        end
        ea = AW'((int'(v.base) + lane_e*MW + n_e) % 32768);
        ed = DW'(lane_e*256 + n_e);
        chk($sformatf("v%0d_w%0d_addr", vi, writes), 32'(bus.wr_addr), 32'(ea));
        chk($sformatf("v%0d_w%0d_data", vi, writes), 32'(bus.wr_data), 32'(ed));
        writes++;
        stall = 0;
      end else begin
        stall  = bus.wr_en;
        s_addr = bus.wr_addr;
        s_data = bus.wr_data;
      end
      for (int k = 0; k < AS; k++)
        if (bus.pool_valid[k] && bus.pool_ready[k]) sent[k]++;
      if (n_err - e0 > 8) break;
      @(negedge clk);
    end

    start = 1'b0;
    bus.pool_valid = '0;
    bus.wr_ready = 1'b1;
    if (aborted) return;

    chk($sformatf("v%0d_write_count", vi), 32'(writes), 32'(v.n_writes));
    if (v.exp_done) begin
      chk("last_done_early", 32'(done), 0);
      chk("last_wr_en_low", 32'(bus.wr_en), 0);
      @(negedge clk);
      chk("pass_done", 32'(done), 1);
      chk("pass_busy", 32'(busy), 0);
      chk("pass_pool_ready", 32'(bus.pool_ready), 0);
      chk("pass_lane_done", 32'(lane_done), 32'(v.exp_ld));
    end else begin
      repeat (3) @(negedge clk);
      chk("part_lane_done", 32'(lane_done), 32'(v.exp_ld));
      chk("part_done", 32'(done), 0);
      chk("part_busy", 32'(busy), 1);
      chk("part_wr_en", 32'(bus.wr_en), 0);
    end
  endtask

  vec_t vecs [8];

  initial begin
    reset = 1'b0; start = 1'b0; start_addr = '0;
    bus.pool_valid = '0; bus.pool_data = '0; bus.wr_ready = 1'b0;

    //        base      lanes   tog rr  writes restart reset exp_ld  done
    vecs[0] = '{15'h0100, 9'h001, 0, 0, 144,   -1,     -1,   9'h001, 0};
    vecs[1] = '{15'h0000, 9'h1FF, 0, 1, 1296,  -1,     -1,   9'h1FF, 1};
    vecs[2] = '{15'h0200, 9'h1FF, 1, 1, 1296,  -1,     -1,   9'h1FF, 1};
    vecs[3] = '{15'h7FF0, 9'h001, 0, 0, 144,   -1,     -1,   9'h001, 0};
    vecs[4] = '{15'h0300, 9'h010, 1, 0, 144,   -1,     -1,   9'h010, 0};
    vecs[5] = '{15'h0100, 9'h001, 0, 0, 144,   20,     -1,   9'h001, 0};
    vecs[6] = '{15'h0040, 9'h1FF, 0, 1, 1296,  -1,     50,   9'h1FF, 1};
    vecs[7] = '{15'h1000, 9'h1FF, 0, 1, 1296,  -1,     -1,   9'h1FF, 1};

    for (int vi = 0; vi < 8; vi++)
      run_vec(vecs[vi], vi);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
